// File: rtl/cpu_memory_pkg.sv
// Shared types and defaults for the CPU memory stage: FSM encoding, request
// classification and the default bus timeout.
package cpu_memory_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam logic [3:0]  SEL_WORD               = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_BUS_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_LOAD,
        REQ_STORE,
        REQ_ILLEGAL
    } req_e;

    function automatic req_e decode_req(input logic rd, input logic wr);
        case ({rd, wr})
            2'b10:   return REQ_LOAD;
            2'b01:   return REQ_STORE;
            2'b11:   return REQ_ILLEGAL;
            default: return REQ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cpu_memory_if.sv
// Data-side bus between the memory stage (master) and the data memory (slave).
interface cpu_memory_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack
    );

endinterface

// File: rtl/cpu_memory.sv
// CPU memory stage: passes ALU results to writeback, or runs one 32-bit load/store
// on the data bus with a cycle timeout, stalling execute while the access is open.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | no access open; register writeback path, accept requests
//   ST_BUS_WAIT | cyc/stb asserted with latched request, waiting for ack
module cpu_memory
    import cpu_memory_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [3:0]          register_write_index_i,
    input  logic                register_write_enable_i,
    input  logic                memory_read_enable_i,
    input  logic                memory_write_enable_i,
    input  logic [31:0]         memory_address_i,
    input  logic [31:0]         result_i,
    cpu_memory_if.master        dwb,
    output logic [3:0]          register_write_index_o,
    output logic                register_write_enable_o,
    output logic [31:0]         result_o,
    output logic                stall_o,
    output logic                bus_error_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e           state_q;
    state_e           state_d;
    req_e             req;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      adr_q;
    logic [31:0]      dat_q;
    logic             we_q;
    logic [3:0]       idx_q;
    logic             timeout;

    assign req = decode_req(memory_read_enable_i, memory_write_enable_i);

    // Remaining-cycles counter: a value of 1 marks the last permitted wait cycle;
    // an ack in that same cycle still completes the transfer.
    assign timeout = (cnt_q == CNT_W'(1)) && !dwb.ack;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req == REQ_LOAD || req == REQ_STORE) begin
                    state_d = ST_BUS_WAIT;
                end
            end
            ST_BUS_WAIT: begin
                if (dwb.ack || timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dwb.cyc = 1'b0;
        dwb.stb = 1'b0;
        dwb.we  = 1'b0;
        dwb.sel = 4'h0;
        stall_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_o = memory_read_enable_i | memory_write_enable_i;
            end
            ST_BUS_WAIT: begin
                dwb.cyc = 1'b1;
                dwb.stb = 1'b1;
                dwb.we  = we_q;
                dwb.sel = SEL_WORD;
                stall_o = !dwb.ack;
            end
            default: ;
        endcase
    end

    assign dwb.adr   = adr_q;
    assign dwb.dat_w = dat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q                   <= '0;
            adr_q                   <= '0;
            dat_q                   <= '0;
            we_q                    <= 1'b0;
            idx_q                   <= '0;
            register_write_enable_o <= 1'b0;
            register_write_index_o  <= '0;
            result_o                <= '0;
            bus_error_o             <= 1'b0;
        end else begin
            register_write_enable_o <= 1'b0;
            bus_error_o             <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    case (req)
                        REQ_NONE: begin
                            register_write_enable_o <= register_write_enable_i;
                            register_write_index_o  <= register_write_index_i;
                            result_o                <= result_i;
                        end
                        REQ_LOAD, REQ_STORE: begin
                            adr_q <= memory_address_i;
                            dat_q <= result_i;
                            we_q  <= (req == REQ_STORE);
                            idx_q <= register_write_index_i;
                            cnt_q <= CNT_W'(TIMEOUT_CYCLES);
                        end
                        default: bus_error_o <= 1'b1;
                    endcase
                end
                ST_BUS_WAIT: begin
                    if (dwb.ack) begin
                        cnt_q <= '0;
                        // Loads always write back, whatever the original enable was.
                        if (!we_q) begin
                            register_write_enable_o <= 1'b1;
                            register_write_index_o  <= idx_q;
                            result_o                <= dwb.dat_r;
                        end
                    end else if (timeout) begin
                        cnt_q       <= '0;
                        bus_error_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cpu_memory.md
CPU_MEMORY -- requirements
Module: cpu_memory

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles in BUS_WAIT before a bus error.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk_i  in  1  clock; all state updates on posedge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 register_write_index_i  in  4  destination register from execute.
REQ-006 register_write_enable_i  in  1  execute requests register writeback.
REQ-007 memory_read_enable_i  in  1  execute requests 32-bit load.
REQ-008 memory_write_enable_i  in  1  execute requests 32-bit store.
REQ-009 memory_address_i  in  32  load/store byte address.
REQ-010 result_i  in  32  ALU result, or store data.
REQ-011 dwb_cyc_o, dwb_stb_o  out  1 each  data bus cycle/strobe.
REQ-012 dwb_we_o  out  1  1=store, 0=load.
REQ-013 dwb_adr_o  out  32  bus address; dwb_sel_o  out  4  byte lanes, always 4'hF during a cycle.
REQ-014 dwb_dat_o  out  32  store data; dwb_dat_i  in  32  load data; dwb_ack_i  in  1  transfer done.
REQ-015 register_write_index_o  out  4; register_write_enable_o  out  1; result_o  out  32  writeback to register file.
REQ-016 stall_o  out  1  holds execute while an access is pending.
REQ-017 bus_error_o  out  1  one-cycle pulse on timeout or illegal request.

Function
REQ-018 SHALL implement FSM with states IDLE and BUS_WAIT.
REQ-019 IDLE, no memory enable: SHALL register register_write_index_i/enable_i/result_i to writeback outputs (1-cycle latency).
REQ-020 IDLE, exactly one memory enable: SHALL latch address, result_i, index and direction; enter BUS_WAIT; drive register_write_enable_o=0 next cycle.
REQ-021 IDLE, both enables high: SHALL start no bus cycle, pulse bus_error_o next cycle, write back nothing, stay IDLE.
REQ-022 BUS_WAIT: dwb_cyc_o=dwb_stb_o=1, dwb_adr_o/dwb_dat_o/dwb_we_o from latched values, stable until ack or timeout.
REQ-023 Outside BUS_WAIT: dwb_cyc_o=dwb_stb_o=dwb_we_o=0; dwb_sel_o=0.
REQ-024 stall_o SHALL be combinational: (IDLE & (read|write enable)) | (BUS_WAIT & !dwb_ack_i).
REQ-025 Load ack: next cycle result_o=dwb_dat_i, register_write_index_o=latched index, register_write_enable_o=1 (regardless of latched register_write_enable_i), for exactly one cycle; return IDLE.
REQ-026 Store ack: return IDLE; register_write_enable_o=0.
REQ-027 SHALL count BUS_WAIT cycles from 1; if count reaches TIMEOUT_CYCLES with no ack, SHALL drop cyc/stb next cycle, pulse bus_error_o, write back nothing, return IDLE.
REQ-028 Ack and final timeout cycle coincident: ack wins, no error.
REQ-029 dwb_ack_i outside BUS_WAIT SHALL be ignored.
REQ-030 Inputs during BUS_WAIT SHALL be ignored (upstream stalled).
REQ-031 Back-to-back accesses: a new request in the IDLE cycle following an ack SHALL be accepted; minimum 2 cycles per access with zero-wait ack.

Reset
REQ-032 On rst_i: state=IDLE, counter=0, dwb_cyc_o=dwb_stb_o=dwb_we_o=0, dwb_sel_o=0, dwb_adr_o=0, dwb_dat_o=0, register_write_enable_o=0, register_write_index_o=0, result_o=0, bus_error_o=0.
REQ-033 Reset during BUS_WAIT SHALL abort the cycle at that edge; no writeback, no bus_error_o.

Structure
REQ-034 TIMEOUT_CYCLES default and FSM state encodings SHALL live in defines.v; counter width = $clog2(TIMEOUT_CYCLES+1).
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 Load 0x00001000, ack after 3 wait cycles, dat_i=0xDEADBEEF, index 5 -> stall_o high 4 cycles; one-cycle writeback r5=0xDEADBEEF.
REQ-037 Store result_i=0x12345678 to 0x00000200, zero-wait ack -> dwb_we_o=1, dat_o=0x12345678, sel=4'hF for one cycle; no writeback.
REQ-038 Non-memory op, index 3, result 0x0000002A -> next cycle r3 write enable with 0x2A; stall_o never high.
REQ-039 Load, ack never arrives, TIMEOUT_CYCLES=8 -> cyc drops after 8 BUS_WAIT cycles; bus_error_o one pulse; no writeback.
REQ-040 Both enables high -> no cyc, bus_error_o pulse; rst_i asserted mid-BUS_WAIT -> all outputs at reset values next cycle, no error.
